// File: rtl/otter_mem_pkg.sv
// Shared types and helpers for the OTTER memory interface stage.
package otter_mem_pkg;

  typedef enum logic {IDLE, BUS} state_e;

  typedef enum logic [1:0] {OP_FETCH, OP_LOAD, OP_STORE} op_e;

  localparam logic [2:0]  F_B  = 3'b000;
  localparam logic [2:0]  F_H  = 3'b001;
  localparam logic [2:0]  F_W  = 3'b010;
  localparam logic [2:0]  F_BU = 3'b100;
  localparam logic [2:0]  F_HU = 3'b101;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  function automatic logic func_ok(input logic [2:0] f);
    return (f == F_B) || (f == F_H) || (f == F_W) || (f == F_BU) || (f == F_HU);
  endfunction

  // Natural alignment of the access size encoded in f[1:0].
  function automatic logic aligned(input logic [2:0] f, input logic [1:0] o);
    case (f[1:0])
      2'b00:   return 1'b1;
      2'b01:   return ~o[0];
      2'b10:   return (o == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/otter_load_ext.sv
// Load lane select and sign/zero extension; purely combinational.
module otter_load_ext
  import otter_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  func,
  output logic [31:0] result
);

  logic [31:0] sh;

  always_comb begin
    sh = word >> {offset, 3'b000};
    case (func)
      F_B:     result = {{24{sh[7]}}, sh[7:0]};
      F_BU:    result = {24'h000000, sh[7:0]};
      F_H:     result = {{16{sh[15]}}, sh[15:0]};
      F_HU:    result = {16'h0000, sh[15:0]};
      default: result = sh;
    endcase
  end

endmodule

// File: rtl/otter_mem_if.sv
// Memory interface stage behind the OTTER CU: one req/ack bus transaction at a time,
// returns registered ir / extended load data, stalls the CU via busy.
module otter_mem_if
  import otter_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read1,
  input  logic              mem_read2,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [2:0]        func,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  op_e               op_q, op_d, sel_op;
  logic [2:0]        func_q, func_d;
  logic [1:0]        off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] ir_q, ir_d, rdata_q, rdata_d, wdata_q, wdata_d;
  logic              err_q, err_d, req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d, sel_addr;
  logic [3:0]        be_q, be_d, st_be;
  logic [DATA_W-1:0] st_wdata, ld_res;
  logic              any_strobe, legal;

  otter_load_ext u_ext (
    .word   (bus_rdata),
    .offset (off_q),
    .func   (func_q),
    .result (ld_res)
  );

  always_comb begin
    any_strobe = mem_write | mem_read2 | mem_read1;
    if (mem_write)      sel_op = OP_STORE;
    else if (mem_read2) sel_op = OP_LOAD;
    else                sel_op = OP_FETCH;
    sel_addr = (sel_op == OP_FETCH) ? pc : daddr;
    legal    = (sel_op == OP_FETCH) ? (pc[1:0] == 2'b00)
                                    : (func_ok(func) && aligned(func, daddr[1:0]));
    busy     = (state_q == BUS) || (any_strobe && legal);

    case (func[1:0])
      2'b00: begin
        st_be    = 4'b0001 << daddr[1:0];
        st_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << daddr[1:0];
        st_wdata = {2{wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = wdata;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    func_d  = func_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (any_strobe && legal) begin
          state_d = BUS;
          req_d   = 1'b1;
          op_d    = sel_op;
          func_d  = func;
          off_d   = daddr[1:0];
          cnt_d   = '0;
          addr_d  = {sel_addr[ADDR_W-1:2], 2'b00};
          we_d    = (sel_op == OP_STORE);
          be_d    = (sel_op == OP_STORE) ? st_be : 4'b1111;
          wdata_d = (sel_op == OP_STORE) ? st_wdata : '0;
        end else if (any_strobe) begin
          err_d = 1'b1;
        end
      end
      BUS: begin
        if (bus_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          cnt_d   = '0;
          if (op_q == OP_FETCH) ir_d = bus_rdata;
          if (op_q == OP_LOAD)  rdata_d = ld_res;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th BUS cycle without an ack: abort.
          state_d = IDLE;
          req_d   = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b1;
          if (op_q == OP_FETCH) ir_d = NOP_INSTR;
          if (op_q == OP_LOAD)  rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_FETCH;
      func_q  <= 3'b000;
      off_q   <= 2'b00;
      cnt_q   <= '0;
      ir_q    <= NOP_INSTR;
      rdata_q <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      func_q  <= func_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  assign ir        = ir_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_otter_mem_if.sv
// Randomized transaction bench for otter_mem_if against a transaction-level model.
module tb_otter_mem_if;
  import otter_mem_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read1, mem_read2, mem_write;
  logic [31:0] pc, daddr, wdata;
  logic [2:0]  func;
  logic [31:0] ir, rdata, bus_addr, bus_wdata, bus_rdata;
  logic        busy, err, bus_req, bus_we, bus_ack;
  logic [3:0]  bus_be;

  otter_mem_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_read1(mem_read1), .mem_read2(mem_read2), .mem_write(mem_write),
    .pc(pc), .daddr(daddr), .func(func), .wdata(wdata),
    .ir(ir), .rdata(rdata), .busy(busy), .err(err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected visible state of the block.
  bit          chk_en = 1'b0;
  logic [31:0] m_ir, m_rdata, m_addr, m_wdata;
  logic        m_err, m_busy, m_req, m_we;
  logic [3:0]  m_be;
  int          busy_cycles;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  function automatic int size_of(input logic [2:0] f);
    case (f[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic legal_ls(input logic [2:0] f, input logic [31:0] a);
    logic valid;
    valid = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
    return valid && ((a % size_of(f)) == 0);
  endfunction

  function automatic logic [31:0] ext_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic [2:0] f);
    logic [31:0]        w;
    logic signed [31:0] s;
    w = word >> (8 * off);
    case (f)
      3'd0: begin s = $signed(w[7:0]);  return s; end
      3'd1: begin s = $signed(w[15:0]); return s; end
      3'd4: return w & 32'h000000FF;
      3'd5: return w & 32'h0000FFFF;
      default: return w;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("bus_req", bus_req, m_req);
      check("err", err, m_err);
      check("ir", ir, m_ir);
      check("rdata", rdata, m_rdata);
      if (m_req) begin
        check("bus_we", bus_we, m_we);
        check("bus_addr", bus_addr, m_addr);
        check("bus_be", bus_be, m_be);
        check("bus_wdata", bus_wdata, m_wdata);
      end
      if (busy) busy_cycles++;
      if (bus_req) begin
        cap_addr  = bus_addr;
        cap_wdata = bus_wdata;
        cap_be    = bus_be;
        cap_we    = bus_we;
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mem_write = 0; mem_read2 = 0; mem_read1 = 0;
      m_busy = 0;
    end
  endtask

  // One CU request; lat = BUS cycle index on which the memory acks (>= TO: never).
  task automatic txn(input logic w, input logic r2, input logic r1,
                     input logic [31:0] p, input logic [31:0] da, input logic [2:0] f,
                     input logic [31:0] wd, input int lat, input logic [31:0] word);
    int   op;
    int   n;
    logic lg;
    logic acked;
    @(posedge clk); #1;
    mem_write = w; mem_read2 = r2; mem_read1 = r1;
    pc = p; daddr = da; func = f; wdata = wd;
    op = w ? 2 : (r2 ? 1 : 0);
    lg = (op == 0) ? ((p % 4) == 0) : legal_ls(f, da);
    m_busy = lg;
    m_req  = 0;
    @(posedge clk); #1;
    mem_write = 0; mem_read2 = 0; mem_read1 = 0;
    if (!lg) begin
      m_err  = 1;
      m_busy = 0;
      return;
    end
    m_req   = 1;
    m_busy  = 1;
    m_we    = (op == 2);
    m_addr  = ((op == 0) ? p : da) & ~32'h3;
    m_be    = 4'hF;
    m_wdata = 32'h0;
    if (op == 2) begin
      n    = size_of(f);
      m_be = 4'h0;
      for (int i = 0; i < 4; i++) begin
        if (i >= da[1:0] && i < da[1:0] + n) m_be[i] = 1'b1;
        m_wdata[8*i +: 8] = wd[8*(i % n) +: 8];
      end
    end
    acked = 0;
    for (int k = 0; k < TO && !acked; k++) begin
      bus_rdata = (k == lat) ? word : $urandom;
      bus_ack   = (k == lat);
      @(posedge clk); #1;
      if (bus_ack) begin
        acked = 1;
        if (op == 0) m_ir = word;
        if (op == 1) m_rdata = ext_load(word, da[1:0], f);
      end
      bus_ack = 0;
    end
    m_req  = 0;
    m_busy = 0;
    if (!acked) begin
      m_err = 1;
      if (op == 0) m_ir = NOP_INSTR;
      if (op == 1) m_rdata = 32'h0;
    end
  endtask

  task automatic do_reset();
    chk_en = 0;
    @(posedge clk); #1;
    rst = 1;
    mem_write = 0; mem_read2 = 0; mem_read1 = 0; bus_ack = 0;
    @(posedge clk); #1;
    rst = 0;
    m_ir = NOP_INSTR; m_rdata = 0; m_err = 0; m_busy = 0; m_req = 0;
    #2;
    check("rst_ir", ir, 32'h00000013);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", err, 1'b0);
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_bus_be", bus_be, 4'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    chk_en = 1;
  endtask

  initial begin
    logic [2:0] lf [5];
    rst = 1; bus_ack = 0; bus_rdata = 0;
    mem_write = 0; mem_read2 = 0; mem_read1 = 0;
    pc = 0; daddr = 0; func = 0; wdata = 0;
    m_ir = NOP_INSTR; m_rdata = 0; m_err = 0; m_busy = 0; m_req = 0;
    m_we = 0; m_addr = 0; m_be = 0; m_wdata = 0;
    lf[0] = 3'd0; lf[1] = 3'd1; lf[2] = 3'd2; lf[3] = 3'd4; lf[4] = 3'd5;
    repeat (2) @(posedge clk);
    do_reset();
    idle(2);

    // Fetch acked on the third BUS cycle: busy spans four cycles.
    busy_cycles = 0;
    txn(0, 0, 1, 32'h100, 32'h0, 3'd0, 32'h0, 2, 32'h00500093);
    check("fetch_addr", cap_addr, 32'h100);
    check("fetch_be", cap_be, 4'hF);
    check("fetch_ir", ir, 32'h00500093);
    idle(1);
    #5;
    check("fetch_busy_cycles", busy_cycles, 32'd4);

    // Byte loads with ack in the first BUS cycle.
    txn(0, 1, 0, 32'h0, 32'h203, 3'd0, 32'h0, 0, 32'h80FFFFFF);
    check("lb_addr", cap_addr, 32'h200);
    check("lb_rdata", rdata, 32'hFFFFFF80);
    txn(0, 1, 0, 32'h0, 32'h203, 3'd4, 32'h0, 0, 32'h80FFFFFF);
    check("lbu_rdata", rdata, 32'h00000080);

    // Halfword store, with lower-priority strobes present.
    txn(1, 1, 1, 32'h7, 32'h42, 3'd1, 32'h1234ABCD, 1, 32'h0);
    check("sh_we", cap_we, 1'b1);
    check("sh_addr", cap_addr, 32'h40);
    check("sh_be", cap_be, 4'b1100);
    check("sh_wdata", cap_wdata, 32'hABCDABCD);

    for (int t = 0; t < 150; t++) begin
      int          op;
      logic [2:0]  f;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      f  = lf[$urandom_range(0, 4)];
      a  = $urandom & ~(32'(size_of(f)) - 32'd1);
      case (op)
        0: txn(0, 0, 1, $urandom & ~32'h3, $urandom, $urandom, $urandom,
               $urandom_range(0, TO - 1), $urandom);
        1: txn(0, 1, 1'($urandom), $urandom, a, f, $urandom,
               $urandom_range(0, TO - 1), $urandom);
        default: txn(1, 1'($urandom), 1'($urandom), $urandom, a, f, $urandom,
                     $urandom_range(0, TO - 1), $urandom);
      endcase
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    // Timeouts after a load and a fetch that left non-reset values behind.
    txn(0, 1, 0, 32'h0, 32'h10, 3'd2, 32'h0, TO - 1, 32'hFFFFFFFF);
    check("lw_last_cycle", rdata, 32'hFFFFFFFF);
    check("no_err_before_to", err, 1'b0);
    txn(0, 1, 0, 32'h0, 32'h14, 3'd2, 32'h0, TO, 32'h0);
    check("to_rdata", rdata, 32'h0);
    check("to_err", err, 1'b1);
    txn(0, 0, 1, 32'h80, 32'h0, 3'd0, 32'h0, 0, 32'h12345678);
    txn(0, 0, 1, 32'h84, 32'h0, 3'd0, 32'h0, TO, 32'h0);
    check("to_ir", ir, 32'h00000013);

    // Illegal accesses raise a sticky err and issue nothing.
    do_reset();
    txn(0, 1, 0, 32'h0, 32'h5, 3'd2, 32'h0, 0, 32'h0);
    check("illegal_err", err, 1'b1);
    txn(0, 0, 1, 32'h102, 32'h0, 3'd0, 32'h0, 0, 32'h0);
    txn(1, 0, 0, 32'h0, 32'h0, 3'd3, 32'h0, 0, 32'h0);
    txn(0, 1, 0, 32'h0, 32'h1, 3'd5, 32'h0, 0, 32'h0);
    txn(0, 1, 0, 32'h0, 32'h8, 3'd2, 32'h0, 1, 32'hCAFEF00D);
    idle(3);
    check("err_sticky", err, 1'b1);

    // Reset in the middle of a BUS cycle.
    chk_en = 0;
    @(posedge clk); #1;
    mem_read2 = 1; daddr = 32'h20; func = 3'd2;
    @(posedge clk); #1;
    mem_read2 = 0;
    check("midrst_req_before", bus_req, 1'b1);
    #2;
    rst = 1;
    #1;
    check("midrst_req_async", bus_req, 1'b0);
    check("midrst_err", err, 1'b0);
    @(posedge clk); #1;
    rst = 0;
    bus_ack = 1; bus_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus_ack = 0;
    check("midrst_rdata", rdata, 32'h0);
    check("midrst_ir", ir, 32'h00000013);
    check("midrst_req_after", bus_req, 1'b0);
    check("midrst_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
